// File: rtl/seg_scan_reader.sv
// -----------------------------------------------------------------------------
// seg_scan_reader
//
// Readback monitor for a multiplexed, active-low seven-segment display bus.
// Samples the shared segment lines and the per-digit enables, waits for each
// (digit, pattern) pair to stay put for STABLE_CYCLES synchronized samples
// (this rejects ghosting while the driver switches digits), decodes the
// pattern back to BCD and assembles a frame of DIGITS values that is offered
// on a valid/ready handshake.
//
// Optional build macro: SEG_SCAN_READER_BLANK_EN
//   defined   : 7'h7F (all segments dark) decodes as a legal blank
//               (value 4'hF, bad flag clear)
//   undefined : 7'h7F is an illegal glyph like any other unknown pattern
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous, active-low reset
//   segment       segment lines, active-low, bit0=a .. bit6=g
//   digit_sel_n   digit enables, active-low, expected one-hot-low
//   frame_ready   consumer accepts the pending frame
//   frame_valid   a frame is pending
//   frame_digits  BCD values, digit k at [4k+3:4k]
//   frame_bad     per-digit flag: captured pattern was not a legal glyph
//   overrun       sticky: a completed frame was dropped
// -----------------------------------------------------------------------------
module seg_scan_reader #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            segment,
   input  logic [DIGITS-1:0]     digit_sel_n,
   input  logic                  frame_ready,
   output logic                  frame_valid,
   output logic [4*DIGITS-1:0]   frame_digits,
   output logic [DIGITS-1:0]     frame_bad,
   output logic                  overrun
);

   localparam int               IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0]       STABLE   = 8'(STABLE_CYCLES);
   localparam logic [DIGITS-1:0] ALL_ONES = '1;

   typedef enum logic {
      COLLECT = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Returns {bad, value}. Patterns are active-low {g,f,e,d,c,b,a}.
   function automatic logic [4:0] decode(input logic [6:0] pat);
      case (pat)
         7'h40:   decode = 5'h00;
         7'h79:   decode = 5'h01;
         7'h24:   decode = 5'h02;
         7'h30:   decode = 5'h03;
         7'h19:   decode = 5'h04;
         7'h12:   decode = 5'h05;
         7'h02:   decode = 5'h06;
         7'h78:   decode = 5'h07;
         7'h00:   decode = 5'h08;
         7'h10:   decode = 5'h09;
`ifdef SEG_SCAN_READER_BLANK_EN
         7'h7F:   decode = 5'h0F;
`endif
         default: decode = 5'h1F;
      endcase
   endfunction

   // ---------------------------------------------------------------- sync
   logic [6:0]        seg_meta_reg, seg_sync_reg;
   logic [DIGITS-1:0] sel_meta_reg, sel_sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_meta_reg <= '0;
         seg_sync_reg <= '0;
         sel_meta_reg <= '0;
         sel_sync_reg <= '0;
      end else begin
         seg_meta_reg <= segment;
         seg_sync_reg <= seg_meta_reg;
         sel_meta_reg <= digit_sel_n;
         sel_sync_reg <= sel_meta_reg;
      end
   end

   // ------------------------------------------------------ select decode
   logic [3:0]    sel_cnt;
   logic [IW-1:0] sel_idx;
   logic          sel_ok;

   always_comb begin
      sel_cnt = '0;
      sel_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!sel_sync_reg[i]) begin
            sel_cnt = sel_cnt + 4'd1;
            sel_idx = IW'(i);
         end
      end
      sel_ok = (sel_cnt == 4'd1);
   end

   // ----------------------------------------------------------- stability
   logic [IW-1:0] prev_idx_reg;
   logic [6:0]    prev_seg_reg;
   logic [7:0]    cnt_reg, cnt_next;
   logic          same_pair, capture;

   assign same_pair = (sel_idx == prev_idx_reg) && (seg_sync_reg == prev_seg_reg);

   always_comb begin
      cnt_next = 8'd0;
      if (sel_ok) begin
         if (!same_pair)
            cnt_next = 8'd1;
         else if (cnt_reg == STABLE)
            cnt_next = STABLE;
         else
            cnt_next = cnt_reg + 8'd1;
      end
   end

   // One capture per dwell: only on the transition into STABLE.
   assign capture = sel_ok && (cnt_next == STABLE) && (cnt_reg != STABLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_idx_reg <= '0;
         prev_seg_reg <= '0;
         cnt_reg      <= '0;
      end else begin
         cnt_reg <= cnt_next;
         if (sel_ok) begin
            prev_idx_reg <= sel_idx;
            prev_seg_reg <= seg_sync_reg;
         end
      end
   end

   // ------------------------------------------------------ working slots
   logic [4:0]        dec;
   logic [DIGITS-1:0] cap_onehot, mask_reg, mask_merged;
   logic              complete;
   logic [4*DIGITS-1:0] merged_digits;
   logic [DIGITS-1:0]   merged_bad;

   assign dec         = decode(seg_sync_reg);
   assign cap_onehot  = capture ? (DIGITS'(1) << sel_idx) : '0;
   assign mask_merged = mask_reg | cap_onehot;
   // The mask is cleared on every completion, so it can only fill on a capture.
   assign complete    = capture && (mask_merged == ALL_ONES);

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_slot
         logic [3:0] slot_val_reg;
         logic       slot_bad_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               slot_val_reg <= '0;
               slot_bad_reg <= 1'b0;
            end else if (cap_onehot[gi]) begin
               slot_val_reg <= dec[3:0];
               slot_bad_reg <= dec[4];
            end
         end

         // Completion must see the value being captured this very cycle.
         assign merged_digits[4*gi +: 4] = cap_onehot[gi] ? dec[3:0] : slot_val_reg;
         assign merged_bad[gi]           = cap_onehot[gi] ? dec[4]   : slot_bad_reg;
      end
   endgenerate

   // ------------------------------------------------------------- frame FSM
   state_t              state_reg;
   logic                frame_valid_reg;
   logic [4*DIGITS-1:0] frame_digits_reg;
   logic [DIGITS-1:0]   frame_bad_reg;
   logic                overrun_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= COLLECT;
         mask_reg         <= '0;
         frame_valid_reg  <= 1'b0;
         frame_digits_reg <= '0;
         frame_bad_reg    <= '0;
         overrun_reg      <= 1'b0;
      end else begin
         mask_reg <= complete ? '0 : mask_merged;
         case (state_reg)
            COLLECT: begin
               if (complete) begin
                  frame_digits_reg <= merged_digits;
                  frame_bad_reg    <= merged_bad;
                  frame_valid_reg  <= 1'b1;
                  state_reg        <= PENDING;
               end
            end
            PENDING: begin
               if (frame_ready) begin
                  if (complete) begin
                     // Back-to-back: hand over the old frame, present the new one.
                     frame_digits_reg <= merged_digits;
                     frame_bad_reg    <= merged_bad;
                  end else begin
                     frame_valid_reg <= 1'b0;
                     state_reg       <= COLLECT;
                  end
               end else if (complete) begin
                  overrun_reg <= 1'b1;
               end
            end
            default: begin
               state_reg       <= COLLECT;
               frame_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign frame_valid  = frame_valid_reg;
   assign frame_digits = frame_digits_reg;
   assign frame_bad    = frame_bad_reg;
   assign overrun      = overrun_reg;

endmodule

// File: tb/tb_seg_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_reader
//
// Directed testbench for seg_scan_reader with DIGITS=4, STABLE_CYCLES=4.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, well away from the next active edge. Expected frames are written
// out by hand from the glyph table.
// -----------------------------------------------------------------------------
module tb_seg_scan_reader;

   localparam int DIGITS = 4;

   logic                 clk;
   logic                 rst_n;
   logic [6:0]           segment;
   logic [DIGITS-1:0]    digit_sel_n;
   logic                 frame_ready;
   logic                 frame_valid;
   logic [4*DIGITS-1:0]  frame_digits;
   logic [DIGITS-1:0]    frame_bad;
   logic                 overrun;

   int checks = 0;
   int errors = 0;

   seg_scan_reader #(
      .DIGITS        (DIGITS),
      .STABLE_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .segment      (segment),
      .digit_sel_n  (digit_sel_n),
      .frame_ready  (frame_ready),
      .frame_valid  (frame_valid),
      .frame_digits (frame_digits),
      .frame_bad    (frame_bad),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      digit_sel_n = '1;
      segment     = 7'h7F;
      hold(n);
   endtask

   task automatic show(input int k, input logic [6:0] pat, input int n);
      logic [DIGITS-1:0] sel;
      sel         = '1;
      sel[k]      = 1'b0;
      digit_sel_n = sel;
      segment     = pat;
      hold(n);
   endtask

   task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
      show(0, p0, 8);
      show(1, p1, 8);
      show(2, p2, 8);
      show(3, p3, 8);
      $display("scan   %h %h %h %h -> valid=%b digits=%h bad=%b overrun=%b",
               p0, p1, p2, p3, frame_valid, frame_digits, frame_bad, overrun);
   endtask

   task automatic accept(input string name);
      frame_ready = 1'b1;
      hold(1);
      frame_ready = 1'b0;
      $display("accept %s -> valid=%b overrun=%b", name, frame_valid, overrun);
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_accept: frame_valid=%b required 0", name, frame_valid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      frame_ready = 1'b0;
      digit_sel_n = '1;
      segment = 7'h7F;
      hold(3);
      checks += 4;
      if (frame_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b required 0", frame_valid); end
      if (frame_digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h required 0000", frame_digits); end
      if (frame_bad !== 4'h0)     begin errors++; $display("FAIL reset_bad: got %b required 0000", frame_bad); end
      if (overrun !== 1'b0)       begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
      rst_n = 1'b1;
      idle(3);
   endtask

   task automatic test_basic();
      show(0, 7'h30, 8);
      show(1, 7'h24, 8);
      show(2, 7'h79, 8);
      show(3, 7'h40, 4);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", frame_valid); end
      hold(4);
      $display("scan   basic -> valid=%b digits=%h bad=%b", frame_valid, frame_digits, frame_bad);
      checks += 4;
      if (frame_valid !== 1'b1)       begin errors++; $display("FAIL basic_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h0123)  begin errors++; $display("FAIL basic_digits: got %h required 0123", frame_digits); end
      if (frame_bad !== 4'b0000)      begin errors++; $display("FAIL basic_bad: got %b required 0000", frame_bad); end
      if (overrun !== 1'b0)           begin errors++; $display("FAIL basic_overrun: got %b required 0", overrun); end
      idle(2);
      accept("basic");
   endtask

   task automatic test_glitch();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < DIGITS; k++) begin
            show(k, 7'h30, 3);
            show(k, 7'h00, 1);
         end
      end
      idle(6);
      $display("scan   glitch -> valid=%b", frame_valid);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b required 0", frame_valid); end
   endtask

   task automatic test_stable_boundary();
      show(0, 7'h10, 4); show(0, 7'h00, 1);
      show(1, 7'h02, 4); show(1, 7'h00, 1);
      show(2, 7'h19, 4); show(2, 7'h00, 1);
      show(3, 7'h24, 4); show(3, 7'h00, 1);
      idle(3);
      $display("scan   boundary -> valid=%b digits=%h bad=%b", frame_valid, frame_digits, frame_bad);
      checks += 2;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL boundary_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h2469) begin errors++; $display("FAIL boundary_digits: got %h required 2469", frame_digits); end
      accept("boundary");
   endtask

   task automatic test_blank();
      logic [3:0] exp_bad;
`ifdef SEG_SCAN_READER_BLANK_EN
      exp_bad = 4'b0000;
`else
      exp_bad = 4'b0100;
`endif
      scan4(7'h19, 7'h12, 7'h7F, 7'h02);
      checks += 3;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL blank_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h6F54) begin errors++; $display("FAIL blank_digits: got %h required 6F54", frame_digits); end
      if (frame_bad !== exp_bad)     begin errors++; $display("FAIL blank_bad: got %b required %b", frame_bad, exp_bad); end
      idle(2);
      accept("blank");
   endtask

   task automatic test_overrun();
      scan4(7'h78, 7'h00, 7'h10, 7'h40);
      checks += 3;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL ovr_first_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h0987) begin errors++; $display("FAIL ovr_first_digits: got %h required 0987", frame_digits); end
      if (overrun !== 1'b0)          begin errors++; $display("FAIL ovr_first_flag: got %b required 0", overrun); end
      scan4(7'h79, 7'h24, 7'h30, 7'h19);
      idle(2);
      checks += 3;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL ovr_kept_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h0987) begin errors++; $display("FAIL ovr_kept_digits: got %h required 0987", frame_digits); end
      if (overrun !== 1'b1)          begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
      accept("overrun");
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
   endtask

   task automatic test_bad_select();
      show(0, 7'h24, 8);
      show(1, 7'h30, 8);
      show(2, 7'h79, 8);
      digit_sel_n = 4'b0011;
      segment     = 7'h40;
      hold(20);
      $display("select 0011 x20 -> valid=%b", frame_valid);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL select_no_capture: got %b required 0", frame_valid); end
      show(3, 7'h12, 8);
      idle(2);
      $display("scan   select resume -> valid=%b digits=%h", frame_valid, frame_digits);
      checks += 3;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL select_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h5132) begin errors++; $display("FAIL select_digits: got %h required 5132", frame_digits); end
      if (frame_bad !== 4'b0000)     begin errors++; $display("FAIL select_bad: got %b required 0000", frame_bad); end
      accept("select");
   endtask

   task automatic test_reset_midframe();
      show(0, 7'h02, 8);
      show(1, 7'h78, 8);
      rst_n = 1'b0;
      digit_sel_n = '1;
      segment = 7'h7F;
      #1;
      $display("reset  midframe -> valid=%b digits=%h bad=%b overrun=%b",
               frame_valid, frame_digits, frame_bad, overrun);
      checks += 4;
      if (frame_valid !== 1'b0)   begin errors++; $display("FAIL mid_reset_valid: got %b required 0", frame_valid); end
      if (frame_digits !== 16'h0) begin errors++; $display("FAIL mid_reset_digits: got %h required 0000", frame_digits); end
      if (frame_bad !== 4'h0)     begin errors++; $display("FAIL mid_reset_bad: got %b required 0000", frame_bad); end
      if (overrun !== 1'b0)       begin errors++; $display("FAIL mid_reset_overrun: got %b required 0", overrun); end
      hold(2);
      rst_n = 1'b1;
      show(2, 7'h10, 8);
      show(3, 7'h00, 8);
      idle(4);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_partial_discard: got %b required 0", frame_valid); end
      show(0, 7'h40, 8);
      show(1, 7'h79, 8);
      idle(2);
      $display("scan   after reset -> valid=%b digits=%h", frame_valid, frame_digits);
      checks += 2;
      if (frame_valid !== 1'b1)      begin errors++; $display("FAIL mid_frame_valid: got %b required 1", frame_valid); end
      if (frame_digits !== 16'h8910) begin errors++; $display("FAIL mid_frame_digits: got %h required 8910", frame_digits); end
      accept("midframe");
      idle(10);
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_single_frame: got %b required 0", frame_valid); end
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_ready = 1'b0;
      digit_sel_n = '1;
      segment     = 7'h7F;
      test_reset();
      test_basic();
      test_glitch();
      test_stable_boundary();
      test_blank();
      test_overrun();
      test_bad_select();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
